// File: rtl/cmsdk_fpga_sram_arbiter_pkg.sv
//==============================================================================
// Module : cmsdk_fpga_sram_arbiter_pkg
// Brief  : Shared state codes, port identifiers and sizing helper for the
//          two-port FPGA SRAM arbiter.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package cmsdk_fpga_sram_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_OWN_A = 2'd1;
    localparam arb_state_t ST_OWN_B = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // One spare bit so MAXBURST-1 always fits, including MAXBURST=1.
    function automatic int burst_cnt_width(input int maxburst);
        return $clog2(maxburst) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmsdk_fpga_sram_arb_burst_cnt.sv
//==============================================================================
// Module : cmsdk_fpga_sram_arb_burst_cnt
// Brief  : Ownership burst counter: clear/increment, saturates at MAXBURST-1,
//          flags the final allowed grant.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module cmsdk_fpga_sram_arb_burst_cnt
    import cmsdk_fpga_sram_arbiter_pkg::*;
#(
    parameter int MAXBURST = 8,
    parameter int CNT_W    = burst_cnt_width(MAXBURST)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_last
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAXBURST - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_base;
    logic [CNT_W-1:0] w_next;

    // Clear and increment together restarts the count at one grant.
    always_comb begin
        w_base = i_clr ? '0 : r_cnt;
        w_next = w_base;
        if (i_inc && (w_base != C_CNT_MAX)) begin
            w_next = w_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_next;
        end
    end

    assign o_last = (r_cnt == C_CNT_MAX);

endmodule

`default_nettype wire

// File: rtl/cmsdk_fpga_sram_arbiter.sv
//==============================================================================
// Module : cmsdk_fpga_sram_arbiter
// Brief  : Shares one single-port block-RAM SRAM between a CPU port (A) and an
//          accelerator port (B); one grant per cycle, tagged read return,
//          bounded ownership bursts.
// Config : SRAM_ARB_ROUND_ROBIN_EN - round-robin idle tie-break (default: A wins)
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module cmsdk_fpga_sram_arbiter
    import cmsdk_fpga_sram_arbiter_pkg::*;
#(
    parameter int AW       = 16,
    parameter int MAXBURST = 8
) (
    input  logic          CLK,
    input  logic          RESET,

    input  logic          A_REQ,
    input  logic [AW-1:0] A_ADDR,
    input  logic [31:0]   A_WDATA,
    input  logic [3:0]    A_WREN,
    output logic          A_GNT,
    output logic          A_RVALID,
    output logic [31:0]   A_RDATA,

    input  logic          B_REQ,
    input  logic [AW-1:0] B_ADDR,
    input  logic [31:0]   B_WDATA,
    input  logic [3:0]    B_WREN,
    output logic          B_GNT,
    output logic          B_RVALID,
    output logic [31:0]   B_RDATA,

    output logic [AW-1:0] SRAM_ADDR,
    output logic [31:0]   SRAM_WDATA,
    output logic [3:0]    SRAM_WREN,
    output logic          SRAM_CS,
    input  logic [31:0]   SRAM_RDATA
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       w_a_gnt;
    logic       w_b_gnt;
    logic       w_cnt_clr;
    logic       w_cnt_inc;
    logic       w_cnt_last;
    logic       w_a_win;
    logic [1:0] r_rd_own;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic r_last_gnt;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_last_gnt <= PORT_A;
        end else if (A_GNT || B_GNT) begin
            r_last_gnt <= B_GNT ? PORT_B : PORT_A;
        end
    end

    assign w_a_win = (r_last_gnt == PORT_B);
`else
    assign w_a_win = 1'b1;
`endif

    // Grant is decided in the same cycle as the request; a departing owner
    // hands over without an idle bubble.
    always_comb begin
        w_a_gnt     = 1'b0;
        w_b_gnt     = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                w_cnt_clr = 1'b1;
                if (A_REQ && (!B_REQ || w_a_win)) begin
                    w_a_gnt     = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = ST_OWN_A;
                end else if (B_REQ) begin
                    w_b_gnt     = 1'b1;
                    w_cnt_inc   = 1'b1;
                    w_state_nxt = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (A_REQ) begin
                    w_a_gnt = 1'b1;
                    if (B_REQ && w_cnt_last) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_OWN_B;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    w_cnt_clr = 1'b1;
                    if (B_REQ) begin
                        w_b_gnt     = 1'b1;
                        w_state_nxt = ST_OWN_B;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_OWN_B: begin
                if (B_REQ) begin
                    w_b_gnt = 1'b1;
                    if (A_REQ && w_cnt_last) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = ST_OWN_A;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end else begin
                    w_cnt_clr = 1'b1;
                    if (A_REQ) begin
                        w_a_gnt     = 1'b1;
                        w_state_nxt = ST_OWN_A;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_clr   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    cmsdk_fpga_sram_arb_burst_cnt #(
        .MAXBURST (MAXBURST)
    ) u_burst_cnt (
        .clk    (CLK),
        .rst    (RESET),
        .i_clr  (w_cnt_clr),
        .i_inc  (w_cnt_inc),
        .o_last (w_cnt_last)
    );

    // Reset masks the combinational grant so nothing reaches the SRAM while held.
    assign A_GNT   = w_a_gnt & ~RESET;
    assign B_GNT   = w_b_gnt & ~RESET;
    assign SRAM_CS = A_GNT | B_GNT;

    assign SRAM_ADDR  = B_GNT ? B_ADDR  : A_ADDR;
    assign SRAM_WDATA = B_GNT ? B_WDATA : A_WDATA;
    assign SRAM_WREN  = A_GNT ? A_WREN  : (B_GNT ? B_WREN : 4'b0000);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rd_own <= 2'b00;
        end else begin
            r_rd_own <= {B_GNT & ~|B_WREN, A_GNT & ~|A_WREN};
        end
    end

    assign A_RVALID = r_rd_own[0];
    assign B_RVALID = r_rd_own[1];
    assign A_RDATA  = r_rd_own[0] ? SRAM_RDATA : 32'h0000_0000;
    assign B_RDATA  = r_rd_own[1] ? SRAM_RDATA : 32'h0000_0000;

endmodule

`default_nettype wire

// File: tb/tb_cmsdk_fpga_sram_arbiter.sv
//==============================================================================
// Module : tb_cmsdk_fpga_sram_arbiter
// Brief  : Self-checking bench for cmsdk_fpga_sram_arbiter with an SRAM model,
//          a reference arbiter model and per-port read-data scoreboards.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_cmsdk_fpga_sram_arbiter;

    localparam int AW = 16;
    localparam int MB = 8;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          A_REQ, B_REQ;
    logic [AW-1:0] A_ADDR, B_ADDR;
    logic [31:0]   A_WDATA, B_WDATA;
    logic [3:0]    A_WREN, B_WREN;
    logic          A_GNT, B_GNT, A_RVALID, B_RVALID;
    logic [31:0]   A_RDATA, B_RDATA;
    logic [AW-1:0] SRAM_ADDR;
    logic [31:0]   SRAM_WDATA, SRAM_RDATA;
    logic [3:0]    SRAM_WREN;
    logic          SRAM_CS;

    always #5 CLK = ~CLK;

    cmsdk_fpga_sram_arbiter #(.AW(AW), .MAXBURST(MB)) dut (
        .CLK(CLK), .RESET(RESET),
        .A_REQ(A_REQ), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA), .A_WREN(A_WREN),
        .A_GNT(A_GNT), .A_RVALID(A_RVALID), .A_RDATA(A_RDATA),
        .B_REQ(B_REQ), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA), .B_WREN(B_WREN),
        .B_GNT(B_GNT), .B_RVALID(B_RVALID), .B_RDATA(B_RDATA),
        .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA), .SRAM_WREN(SRAM_WREN),
        .SRAM_CS(SRAM_CS), .SRAM_RDATA(SRAM_RDATA)
    );

    function automatic logic [31:0] pre(input int i);
        logic [31:0] v;
        v = i;
        return {16'hC0DE, v[15:0]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] we);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    // External block-RAM model: registered read, byte-enabled write.
    logic [31:0] sram_mem [0:65535];
    logic        sram_init = 1'b0;
    always @(posedge CLK) begin
        if (!sram_init) begin
            for (int i = 0; i < 65536; i++) sram_mem[i] <= pre(i);
            sram_init <= 1'b1;
        end else if (SRAM_CS) begin
            if (SRAM_WREN == 4'b0000) SRAM_RDATA <= sram_mem[SRAM_ADDR];
            else sram_mem[SRAM_ADDR] <= merge(sram_mem[SRAM_ADDR], SRAM_WDATA, SRAM_WREN);
        end
    end

    int          n_err = 0;
    int          n_checks = 0;
    logic [31:0] ref_mem [0:65535];
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          m_own, m_used, wa, wb;
    bit          m_last_b, exp_rva, exp_rvb, obs_ga, obs_gb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arbiter: owner plus number of grants used in the current burst.
    function automatic void model_grant(output bit ga, output bit gb);
        ga = 1'b0;
        gb = 1'b0;
        if (RESET) return;
        case (m_own)
            0: begin
                if (A_REQ && B_REQ) begin
                    ga = RR ? m_last_b : 1'b1;
                    gb = !ga;
                end else begin
                    ga = A_REQ;
                    gb = B_REQ;
                end
            end
            1: begin ga = A_REQ; gb = !A_REQ && B_REQ; end
            default: begin gb = B_REQ; ga = !B_REQ && A_REQ; end
        endcase
    endfunction

    function automatic void model_update(input bit ga, input bit gb, input bit areq, input bit breq);
        if (ga || gb) m_last_b = gb;
        case (m_own)
            0: begin
                if (ga) begin m_own = 1; m_used = 1; end
                else if (gb) begin m_own = 2; m_used = 1; end
            end
            1: begin
                if (ga) begin
                    if (breq && m_used >= MB - 1) begin m_own = 2; m_used = 0; end
                    else m_used++;
                end else if (gb) begin m_own = 2; m_used = 0; end
                else begin m_own = 0; m_used = 0; end
            end
            default: begin
                if (gb) begin
                    if (areq && m_used >= MB - 1) begin m_own = 1; m_used = 0; end
                    else m_used++;
                end else if (ga) begin m_own = 1; m_used = 0; end
                else begin m_own = 0; m_used = 0; end
            end
        endcase
    endfunction

    task automatic do_reset();
        RESET = 1'b1;
        A_REQ = 1'b0;
        B_REQ = 1'b0;
        m_own = 0; m_used = 0; m_last_b = 1'b0;
        exp_rva = 1'b0; exp_rvb = 1'b0;
        qa.delete(); qb.delete();
        wa = 0; wb = 0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    // Called 1 unit after a rising edge with inputs already applied.
    task automatic step();
        bit ga, gb, nrva, nrvb, areq, breq;
        #4;
        model_grant(ga, gb);
        areq = A_REQ;
        breq = B_REQ;
        obs_ga = A_GNT;
        obs_gb = B_GNT;
        chk("a_gnt", A_GNT, ga);
        chk("b_gnt", B_GNT, gb);
        chk("sram_cs", SRAM_CS, ga | gb);
        chk("dual_gnt", A_GNT & B_GNT, 0);
        if (ga) begin chk("a_sram_addr", SRAM_ADDR, A_ADDR); chk("a_sram_wren", SRAM_WREN, A_WREN); end
        if (gb) begin chk("b_sram_addr", SRAM_ADDR, B_ADDR); chk("b_sram_wren", SRAM_WREN, B_WREN); end
        if (!ga && !gb) chk("idle_wren", SRAM_WREN, 0);
        chk("a_rvalid", A_RVALID, exp_rva);
        if (exp_rva) begin
            if (qa.size() == 0) begin n_checks++; n_err++; $display("FAIL a_scoreboard: got empty queue expected entry"); end
            else chk("a_rdata", A_RDATA, qa.pop_front());
        end else chk("a_rdata_zero", A_RDATA, 0);
        chk("b_rvalid", B_RVALID, exp_rvb);
        if (exp_rvb) begin
            if (qb.size() == 0) begin n_checks++; n_err++; $display("FAIL b_scoreboard: got empty queue expected entry"); end
            else chk("b_rdata", B_RDATA, qb.pop_front());
        end else chk("b_rdata_zero", B_RDATA, 0);
        nrva = ga && (A_WREN == 4'b0000);
        nrvb = gb && (B_WREN == 4'b0000);
        if (nrva) qa.push_back(ref_mem[A_ADDR]);
        if (nrvb) qb.push_back(ref_mem[B_ADDR]);
        if (ga && A_WREN != 4'b0000) ref_mem[A_ADDR] = merge(ref_mem[A_ADDR], A_WDATA, A_WREN);
        if (gb && B_WREN != 4'b0000) ref_mem[B_ADDR] = merge(ref_mem[B_ADDR], B_WDATA, B_WREN);
        if (A_REQ && !A_GNT) wa++;
        if (B_REQ && !B_GNT) wb++;
        if (A_GNT) begin chk("a_wait_bound", wa <= MB + 1, 1); wa = 0; end
        if (B_GNT) begin chk("b_wait_bound", wb <= MB + 1, 1); wb = 0; end
        @(posedge CLK);
        model_update(ga, gb, areq, breq);
        exp_rva = nrva;
        exp_rvb = nrvb;
        #1;
    endtask

    typedef struct {
        bit       rst, areq, breq;
        logic [3:0] awren, bwren;
        bit       ega, egb;
        logic [3:0] ewren;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int   na, first_b;

        A_REQ = 0; B_REQ = 0; A_ADDR = 0; B_ADDR = 0;
        A_WDATA = 0; B_WDATA = 0; A_WREN = 0; B_WREN = 0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = pre(i);

        vecs[0] = '{0, 0, 0, 4'h0, 4'h0, 0, 0, 4'h0};
        vecs[1] = '{0, 1, 0, 4'h0, 4'h0, 1, 0, 4'h0};
        vecs[2] = '{0, 0, 1, 4'h0, 4'h0, 0, 1, 4'h0};
        vecs[3] = '{0, 1, 1, 4'h0, 4'h0, !RR, RR, 4'h0};
        vecs[4] = '{0, 1, 0, 4'h3, 4'h0, 1, 0, 4'h3};
        vecs[5] = '{0, 0, 1, 4'h0, 4'hF, 0, 1, 4'hF};
        vecs[6] = '{1, 1, 0, 4'h0, 4'h0, 0, 0, 4'h0};
        vecs[7] = '{1, 1, 1, 4'h5, 4'hA, 0, 0, 4'h0};

        // Single-cycle grant decisions out of IDLE, including reset masking.
        for (int i = 0; i < 8; i++) begin
            do_reset();
            A_ADDR = AW'(16'h40 + i);
            B_ADDR = AW'(16'h80 + i);
            RESET  = vecs[i].rst;
            A_REQ  = vecs[i].areq;
            B_REQ  = vecs[i].breq;
            A_WREN = vecs[i].awren;
            B_WREN = vecs[i].bwren;
            #2;
            chk("vec_a_gnt", A_GNT, vecs[i].ega);
            chk("vec_b_gnt", B_GNT, vecs[i].egb);
            chk("vec_cs", SRAM_CS, vecs[i].ega | vecs[i].egb);
            chk("vec_wren", SRAM_WREN, vecs[i].ewren);
            chk("vec_addr", SRAM_ADDR, vecs[i].egb ? B_ADDR : A_ADDR);
            chk("vec_rvalid", {A_RVALID, B_RVALID}, 0);
            A_REQ = 0; B_REQ = 0; A_WREN = 0; B_WREN = 0; RESET = 0;
        end

        // Back-to-back A reads return preloaded data one cycle later.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            A_REQ = 1; A_ADDR = AW'(16'h10 + i);
            step();
            chk("t1_a_gnt", obs_ga, 1);
            chk("t1_a_rvalid", A_RVALID, 1);
            chk("t1_a_rdata", A_RDATA, 32'hC0DE0010 + i);
            chk("t1_b_rvalid", B_RVALID, 0);
        end
        A_REQ = 0;
        step();
        step();

        // Simultaneous request from IDLE after a prior A grant.
        do_reset();
        A_REQ = 1; A_ADDR = 16'h0005;
        step();
        A_REQ = 0;
        step();
        A_REQ = 1; B_REQ = 1; B_ADDR = 16'h0006;
        step();
        chk("t2_a_first", obs_ga, !RR);
        chk("t2_b_first", obs_gb, RR);
        if (obs_ga) A_REQ = 0;
        if (obs_gb) B_REQ = 0;
        step();
        chk("t2_loser_next", obs_ga | obs_gb, 1);
        A_REQ = 0; B_REQ = 0;
        step();

        // Burst limit: A streams, B arrives at cycle 2.
        do_reset();
        na = 0; first_b = -1;
        A_ADDR = 16'h0050; B_ADDR = 16'h0051;
        for (int c = 0; c < 20; c++) begin
            A_REQ = 1;
            B_REQ = (c >= 2) && (first_b < 0);
            step();
            if (obs_gb && first_b < 0) first_b = c;
            if (obs_ga && first_b < 0) na++;
        end
        chk("t3_a_grants", na, MB);
        chk("t3_b_gnt_cycle", first_b, MB);
        A_REQ = 0; B_REQ = 0;
        step();

        // Partial write by A then read by B of the same word.
        do_reset();
        A_REQ = 1; A_ADDR = 16'h0020; A_WDATA = 32'hDEADBEEF; A_WREN = 4'b0011;
        step();
        chk("t4_a_rvalid_wr", A_RVALID, 0);
        A_REQ = 0; A_WREN = 0;
        B_REQ = 1; B_ADDR = 16'h0020; B_WREN = 0;
        step();
        B_REQ = 0;
        chk("t4_b_rvalid", B_RVALID, 1);
        chk("t4_b_rdata", B_RDATA, 32'hC0DEBEEF);
        chk("t4_a_rvalid", A_RVALID, 0);
        step();

        // Reset lands while a B read is returning.
        do_reset();
        B_REQ = 1; B_ADDR = 16'h0030;
        step();
        chk("t5_b_gnt", obs_gb, 1);
        B_REQ = 0;
        RESET = 1; A_REQ = 1;
        #1;
        chk("t5_b_rvalid", B_RVALID, 0);
        chk("t5_b_rdata", B_RDATA, 0);
        chk("t5_gnt", {A_GNT, B_GNT}, 0);
        chk("t5_cs", SRAM_CS, 0);
        do_reset();
        A_REQ = 1; A_ADDR = 16'h0031;
        step();
        chk("t5_post_reset_gnt", obs_ga, 1);
        A_REQ = 0;
        step();

        // Random traffic against the reference model and scoreboards.
        do_reset();
        for (int n = 0; n < 10000; n++) begin
            if (!A_REQ && $urandom_range(0, 1) == 1) begin
                A_REQ = 1; A_ADDR = AW'($urandom_range(0, 31)); A_WDATA = $urandom;
                A_WREN = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            if (!B_REQ && $urandom_range(0, 2) != 0) begin
                B_REQ = 1; B_ADDR = AW'($urandom_range(0, 31)); B_WDATA = $urandom;
                B_WREN = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            step();
            if (obs_ga) A_REQ = 0;
            if (obs_gb) B_REQ = 0;
        end
        A_REQ = 0; B_REQ = 0;
        step();
        step();
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
